// File: rtl/ctrl_pkg.sv
// Types and constants shared by the control loop: filter, PID controller and plant/noise models.
package ctrl_pkg;

    localparam int DEFAULT_W = 16;

    typedef logic signed [DEFAULT_W-1:0] sample_t;

endpackage

// File: rtl/ma_delay_line.sv
// Circular window of the last N samples; the word at the write pointer is read out
// combinationally so it can be subtracted before being overwritten on the same edge.
module ma_delay_line
    import ctrl_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int LOG2_N = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_flush,
    input  logic                i_wr_en,
    input  logic signed [W-1:0] i_wr_data,
    output logic signed [W-1:0] o_rd_data
);

    localparam int N = 1 << LOG2_N;

    logic signed [W-1:0] r_buf [N];
    logic [LOG2_N-1:0]   r_ptr;

    // Oldest sample in the window; it leaves the sum when a new one arrives.
    assign o_rd_data = r_buf[r_ptr];

    // Window storage: zeroed on reset/flush, overwritten oldest-first on each write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= {W{1'b0}};
            end
            r_ptr <= {LOG2_N{1'b0}};
        end else if (i_flush) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= {W{1'b0}};
            end
            r_ptr <= {LOG2_N{1'b0}};
        end else if (i_wr_en) begin
            r_buf[r_ptr] <= i_wr_data;
            r_ptr        <= r_ptr + LOG2_N'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar moving-average filter between the raw sensor stream and the PID measurement input.
// Running sum updated with one add and one subtract per sample; divide by N is a shift.
module moving_average_filter
    import ctrl_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int LOG2_N = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic signed [W-1:0] s_axi_tdata,
    input  logic                s_axi_tvalid,
    output logic                s_axi_tready,
    output logic signed [W-1:0] m_axi_tdata,
    output logic                m_axi_tvalid,
    input  logic                m_axi_tready,
    input  logic                flush,
    output logic                filled
);

    localparam int              AW       = W + LOG2_N;
    localparam logic [LOG2_N:0] CNT_FULL = (LOG2_N + 1)'(32'd1 << LOG2_N);

    logic signed [AW-1:0] r_acc;
    logic [LOG2_N:0]      r_cnt;
    logic signed [W-1:0]  r_tdata;
    logic                 r_tvalid;
    logic                 r_filled;

    logic signed [W-1:0]  w_rd_data;
    logic                 w_accept;
    logic signed [AW-1:0] w_sum;
    logic signed [W-1:0]  w_avg;
    logic [LOG2_N:0]      w_cnt_next;

    // Single-entry slice: take a sample only if the output slot is free or being drained.
    assign s_axi_tready = reset_n && (!r_tvalid || m_axi_tready) && !flush;
    assign w_accept     = s_axi_tvalid && s_axi_tready;

    assign m_axi_tdata  = r_tdata;
    assign m_axi_tvalid = r_tvalid;
    assign filled       = r_filled;

    ma_delay_line #(
        .W      (W),
        .LOG2_N (LOG2_N)
    ) u_delay_line (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (flush),
        .i_wr_en   (w_accept),
        .i_wr_data (s_axi_tdata),
        .o_rd_data (w_rd_data)
    );

    // Next running sum, its average and the saturating fill count.
    always_comb begin
        w_sum = r_acc
              + {{LOG2_N{s_axi_tdata[W-1]}}, s_axi_tdata}
              - {{LOG2_N{w_rd_data[W-1]}}, w_rd_data};
        // Taking the top W bits of the sum is the arithmetic shift right by LOG2_N.
        w_avg = w_sum[AW-1:LOG2_N];
        if (r_cnt == CNT_FULL) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + (LOG2_N + 1)'(1);
        end
    end

    // Sum, fill tracking and output register; flush outranks any accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= {AW{1'b0}};
            r_cnt    <= {(LOG2_N + 1){1'b0}};
            r_tdata  <= {W{1'b0}};
            r_tvalid <= 1'b0;
            r_filled <= 1'b0;
        end else if (flush) begin
            r_acc    <= {AW{1'b0}};
            r_cnt    <= {(LOG2_N + 1){1'b0}};
            r_tdata  <= {W{1'b0}};
            r_tvalid <= 1'b0;
            r_filled <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= w_sum;
            r_cnt    <= w_cnt_next;
            r_tdata  <= w_avg;
            r_tvalid <= 1'b1;
            r_filled <= (w_cnt_next == CNT_FULL);
        end else if (m_axi_tready) begin
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= r_tvalid;
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter (W=16, N=8) with hand-computed expected outputs.
module tb_moving_average_filter;

    logic               clk;
    logic               reset_n;
    logic signed [15:0] s_axi_tdata;
    logic               s_axi_tvalid;
    logic               s_axi_tready;
    logic signed [15:0] m_axi_tdata;
    logic               m_axi_tvalid;
    logic               m_axi_tready;
    logic               flush;
    logic               filled;

    int n_vec;
    int n_err;

    moving_average_filter #(
        .W      (16),
        .LOG2_N (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_axi_tdata  (s_axi_tdata),
        .s_axi_tvalid (s_axi_tvalid),
        .s_axi_tready (s_axi_tready),
        .m_axi_tdata  (m_axi_tdata),
        .m_axi_tvalid (m_axi_tvalid),
        .m_axi_tready (m_axi_tready),
        .flush        (flush),
        .filled       (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one edge, then sample outputs 1 time unit later.
    task automatic push(input int x);
        s_axi_tdata  = 16'(x);
        s_axi_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_tvalid = 1'b0;
    endtask

    // One flush cycle, optionally with a sample offered alongside it.
    task automatic do_flush(input logic with_valid, input int x);
        flush        = 1'b1;
        s_axi_tvalid = with_valid;
        s_axi_tdata  = 16'(x);
        #1;
        chk("tready_in_flush", int'(s_axi_tready), 0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        s_axi_tvalid = 1'b0;
        chk("flush_tvalid", int'(m_axi_tvalid), 0);
        chk("flush_filled", int'(filled), 0);
    endtask

    initial begin
        int ramp [10];
        int wrap [9];
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        s_axi_tdata  = 16'sd0;
        s_axi_tvalid = 1'b0;
        m_axi_tready = 1'b1;
        flush        = 1'b0;
        ramp = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800};
        wrap = '{0, 0, 0, 1, 1, 2, 3, 4, 5};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_tready", int'(s_axi_tready), 0);
        chk("rst_tvalid", int'(m_axi_tvalid), 0);
        chk("rst_tdata", int'(m_axi_tdata), 0);
        chk("rst_filled", int'(filled), 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_tready", int'(s_axi_tready), 1);

        // Step response with constant 800
        for (int i = 0; i < 10; i++) begin
            push(800);
            chk("step_tvalid", int'(m_axi_tvalid), 1);
            chk($sformatf("step_%0d", i), int'(m_axi_tdata), ramp[i]);
            chk($sformatf("step_filled_%0d", i), int'(filled), (i >= 7) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        chk("idle_tvalid_clears", int'(m_axi_tvalid), 0);

        // Flush mid-stream with a sample offered in the flush cycle
        do_flush(1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            push(400);
            chk($sformatf("flush_pre_%0d", i), int'(m_axi_tdata), 50 * (i + 1));
        end
        do_flush(1'b1, 400);
        push(800);
        chk("after_flush", int'(m_axi_tdata), 100);

        // Wrap-around with samples 1..9
        do_flush(1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            push(i + 1);
            chk($sformatf("wrap_%0d", i), int'(m_axi_tdata), wrap[i]);
        end

        // Negative rounding toward minus infinity
        do_flush(1'b0, 0);
        push(-1);
        chk("neg_m1", int'(m_axi_tdata), -1);
        do_flush(1'b0, 0);
        push(-9);
        chk("neg_m9", int'(m_axi_tdata), -2);

        // Full-scale alternating window
        do_flush(1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            push((i % 2 == 0) ? 32767 : -32768);
            chk($sformatf("alt_%0d", i), int'(m_axi_tdata), (i % 2 == 0) ? 4095 : -1);
        end
        chk("alt_filled", int'(filled), 1);

        // Backpressure: one pending output held while the sink stalls
        do_flush(1'b0, 0);
        push(10);
        chk("bp_a", int'(m_axi_tdata), 1);
        push(20);
        chk("bp_b", int'(m_axi_tdata), 3);
        m_axi_tready = 1'b0;
        s_axi_tdata  = 16'sd40;
        s_axi_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_tready", int'(s_axi_tready), 0);
            @(posedge clk);
            #1;
            chk("bp_tvalid", int'(m_axi_tvalid), 1);
            chk("bp_hold", int'(m_axi_tdata), 3);
        end
        m_axi_tready = 1'b1;
        #1;
        chk("bp_release_tready", int'(s_axi_tready), 1);
        @(posedge clk);
        #1;
        chk("bp_c", int'(m_axi_tdata), 8);
        push(50);
        chk("bp_d", int'(m_axi_tdata), 15);
        @(posedge clk);
        #1;
        chk("bp_drain", int'(m_axi_tvalid), 0);

        // Asynchronous reset mid-stream
        do_flush(1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            push(300);
        end
        chk("pre_rst_tvalid", int'(m_axi_tvalid), 1);
        chk("pre_rst_filled", int'(filled), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_tvalid", int'(m_axi_tvalid), 0);
        chk("async_rst_filled", int'(filled), 0);
        chk("async_rst_tready", int'(s_axi_tready), 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(800);
            chk($sformatf("rst_ramp_%0d", i), int'(m_axi_tdata), ramp[i]);
        end
        chk("rst_ramp_filled", int'(filled), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Boxcar moving-average filter for noisy plant measurement samples, sitting directly upstream of the PID controller: it consumes raw sensor samples on an AXI-Stream slave and presents the smoothed sample on an AXI-Stream master wired to the controller's measurement input. It keeps an N-deep circular delay line and a running sum, so each accepted sample costs one add and one subtract regardless of N. N is a power of two, so the divide is an arithmetic shift.

## Interface
- W, 16: sample width, signed two's complement, in and out.
- LOG2_N, 3: log2 of window length N (N = 8 default); legal range 1..6.

- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_axi_tdata  in  W  signed raw measurement sample.
- s_axi_tvalid  in  1  input sample valid.
- s_axi_tready  out  1  filter can accept a sample this cycle.
- m_axi_tdata  out  W  signed filtered sample.
- m_axi_tvalid  out  1  filtered sample valid.
- m_axi_tready  in  1  downstream (PID) accepts.
- flush  in  1  synchronous clear of window, sum and pending output.
- filled  out  1  high once N samples accepted since reset/last flush.

## Operation
- State: delay line buf[0..N-1] (W each), write pointer ptr (LOG2_N bits), running sum acc (W+LOG2_N bits signed), fill counter cnt (LOG2_N+1 bits, saturates at N), output register.
- Accept = s_axi_tvalid && s_axi_tready.
- On accept: acc <= acc + x - buf[ptr]; buf[ptr] <= x; ptr <= ptr + 1 (wraps N-1 -> 0 naturally); cnt <= min(cnt+1, N); m_axi_tdata <= (acc + x - buf[ptr]) >>> LOG2_N; m_axi_tvalid <= 1.
- acc width W+LOG2_N never overflows; the shifted result always fits in W, no saturation needed.
- Shift is arithmetic: rounds toward negative infinity (-1 >>> 3 = -1, -9 >>> 3 = -2).
- Fill phase: buf starts at zero, so outputs ramp during the first N samples (divisor is always N, never cnt). filled = (cnt == N).
- flush (priority over everything except reset): buf all zero, acc = 0, ptr = 0, cnt = 0, m_axi_tvalid = 0, in one cycle. A sample presented in a flush cycle is not accepted.

## Timing
- Reset values: s_axi_tready = 0 during reset; after reset m_axi_tvalid = 0, m_axi_tdata = 0, filled = 0; buf, acc, ptr, cnt all zero.
- s_axi_tready = (!m_axi_tvalid || m_axi_tready) && !flush. This is combinational, a single-entry register slice with no skid buffer.
- Latency: 1 cycle, from accept at edge k to m_axi_tvalid high after edge k.
- Throughput: 1 sample/cycle while m_axi_tready = 1.
- m_axi_tvalid clears on an edge with m_axi_tready = 1 and no new accept. Accept plus output handoff in the same cycle keeps m_axi_tvalid = 1 with new data.
- While m_axi_tvalid && !m_axi_tready: m_axi_tdata held stable, no accept, window state frozen.
- Reset mid-stream: all state is discarded immediately (asynchronous). The first post-reset output reflects only post-reset samples.
- filled rises on the edge that accepts the Nth sample. It stays high until flush or reset.

## Structure
- Shared package ctrl_pkg: sample type sample_t (signed [W-1:0] at default W) and localparam DEFAULT_W = 16, both shared with the PID controller and noise/plant blocks.
- One sub-module: ma_delay_line (circular register array with ptr, zero-on-flush, read-before-write at ptr). The sum, fill counter and handshake stay in the top.
- Delay line is registers, not RAM, because single-cycle flush needs it.

## Test plan
- Step response: N = 8, ready held high, constant 800 for 10 samples -> outputs 100, 200, …, 800, then 800, 800; filled rises with the 8th output.
- Wrap-around: samples 1..9 -> 9th output = (2+…+9) >>> 3 = 44 >>> 3 = 5; 8th output = 36 >>> 3 = 4.
- Negative rounding: after flush, single sample -1 -> output -1; after flush, single sample -9 -> output -2. Alternating ±32767/-32768 over a full window -> no overflow; output is -1 (sum -4 >>> 3).
- Backpressure: m_axi_tready low for 5 cycles with s_axi_tvalid high -> exactly one output pending, s_axi_tready = 0, m_axi_tdata stable. Release -> no sample lost or duplicated, ordering intact.
- Flush mid-stream: 5 samples of 400, then flush asserted together with s_axi_tvalid -> sample not accepted, m_axi_tvalid = 0, filled = 0. Next sample 800 -> output 100.
- Async reset mid-stream: assert reset_n low between edges with m_axi_tvalid = 1 -> m_axi_tvalid and filled drop immediately. After release, constant 800 reproduces the 100…800 ramp.
